// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel |Gx|+|Gy| over two line buffers, run-time line width, saturated or binary output.
// Three register stages that share one stall (~m_valid_o | m_ready_i), so the input stalls with the output.
module sobel_stream #(
  parameter int WIDTH_P      = 8,
  parameter int OUT_W_P      = 8,
  parameter int MAX_LINE_W_P = 1024,
  parameter int XW_P         = $clog2(MAX_LINE_W_P)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [XW_P:0]      cfg_width_i,
  input  logic               cfg_mode_i,
  input  logic [OUT_W_P-1:0] cfg_thresh_i,
  input  logic [WIDTH_P-1:0] s_data_i,
  input  logic               s_user_i,
  input  logic               s_last_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  output logic [OUT_W_P-1:0] m_data_o,
  output logic               m_user_o,
  output logic               m_last_o,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic               line_err_o,
  output logic               frame_done_o
);

  localparam int YW = 16;
  localparam int PW = WIDTH_P + 2;
  localparam int GW = WIDTH_P + 3;
  localparam int SW = WIDTH_P + 4;
  localparam int CW = (SW > OUT_W_P) ? SW : OUT_W_P;
  localparam logic [CW-1:0] OUT_MAX = CW'({OUT_W_P{1'b1}});

  logic adv;
  logic run_q;
  logic in_beat;

  // run_q keeps s_ready_o low while reset is asserted and for the first edge after it
  assign adv       = ~m_valid_o | m_ready_i;
  assign s_ready_o = adv & run_q;
  assign in_beat   = s_valid_i & s_ready_o;

  logic [XW_P:0]      w_q;
  logic               mode_q;
  logic [OUT_W_P-1:0] thr_q;
  logic [XW_P-1:0]    x_q;
  logic [YW-1:0]      y_q;

  logic [XW_P:0]      w_eff;
  logic               mode_eff;
  logic [OUT_W_P-1:0] thr_eff;
  logic [XW_P-1:0]    pos_x;
  logic [YW-1:0]      pos_y;
  logic               at_end;
  logic               bad_eol;

  // The SOF beat itself already uses the configuration presented with it
  always_comb begin
    w_eff    = s_user_i ? cfg_width_i  : w_q;
    mode_eff = s_user_i ? cfg_mode_i   : mode_q;
    thr_eff  = s_user_i ? cfg_thresh_i : thr_q;
    pos_x    = s_user_i ? '0 : x_q;
    pos_y    = s_user_i ? '0 : y_q;
    at_end   = ({1'b0, pos_x} == (w_eff - (XW_P+1)'(1)));
    bad_eol  = s_last_i ^ at_end;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      run_q      <= 1'b0;
      w_q        <= (XW_P+1)'(MAX_LINE_W_P);
      mode_q     <= 1'b0;
      thr_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      line_err_o <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (in_beat) begin
        if (s_user_i) begin
          w_q    <= cfg_width_i;
          mode_q <= cfg_mode_i;
          thr_q  <= cfg_thresh_i;
        end
        if (s_last_i || at_end) begin
          x_q <= '0;
          y_q <= (&pos_y) ? pos_y : pos_y + YW'(1);
        end else begin
          x_q <= pos_x + XW_P'(1);
          y_q <= pos_y;
        end
        line_err_o <= (line_err_o & ~s_user_i) | bad_eol;
      end
    end
  end

  logic [WIDTH_P-1:0] lb0 [MAX_LINE_W_P];
  logic [WIDTH_P-1:0] lb1 [MAX_LINE_W_P];
  logic [WIDTH_P-1:0] lb0_rd;
  logic [WIDTH_P-1:0] lb1_rd;
  logic [WIDTH_P-1:0] win [3][3];

  assign lb0_rd = lb0[pos_x];
  assign lb1_rd = lb1[pos_x];

  // win[r][c]: row 0 is two lines back, column 2 is the newest pixel
  always_ff @(posedge clk_i) begin
    if (in_beat) begin
      lb0[pos_x] <= s_data_i;
      lb1[pos_x] <= lb0_rd;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_rd;
      win[1][2] <= lb0_rd;
      win[2][2] <= s_data_i;
    end
  end

  logic               v1, u1, l1, b1, md1;
  logic [OUT_W_P-1:0] th1;
  logic [YW-1:0]      row1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1   <= 1'b0;
      u1   <= 1'b0;
      l1   <= 1'b0;
      b1   <= 1'b0;
      md1  <= 1'b0;
      th1  <= '0;
      row1 <= '0;
    end else if (adv) begin
      v1 <= in_beat;
      if (in_beat) begin
        u1   <= s_user_i;
        l1   <= s_last_i;
        b1   <= (pos_y < YW'(2)) | (pos_x < XW_P'(2));
        md1  <= mode_eff;
        th1  <= thr_eff;
        row1 <= pos_y;
      end
    end
  end

  logic [PW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [GW-1:0] gx_c, gy_c;

  // Differences are kept as GW-bit two's complement; the operands never exceed PW bits
  always_comb begin
    gx_pos = PW'(win[0][2]) + PW'({win[1][2], 1'b0}) + PW'(win[2][2]);
    gx_neg = PW'(win[0][0]) + PW'({win[1][0], 1'b0}) + PW'(win[2][0]);
    gy_pos = PW'(win[2][0]) + PW'({win[2][1], 1'b0}) + PW'(win[2][2]);
    gy_neg = PW'(win[0][0]) + PW'({win[0][1], 1'b0}) + PW'(win[0][2]);
    gx_c   = {1'b0, gx_pos} - {1'b0, gx_neg};
    gy_c   = {1'b0, gy_pos} - {1'b0, gy_neg};
  end

  logic               v2, u2, l2, b2, md2;
  logic [OUT_W_P-1:0] th2;
  logic [YW-1:0]      row2;
  logic [GW-1:0]      gx2, gy2;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v2   <= 1'b0;
      u2   <= 1'b0;
      l2   <= 1'b0;
      b2   <= 1'b0;
      md2  <= 1'b0;
      th2  <= '0;
      row2 <= '0;
      gx2  <= '0;
      gy2  <= '0;
    end else if (adv) begin
      v2   <= v1;
      u2   <= u1;
      l2   <= l1;
      b2   <= b1;
      md2  <= md1;
      th2  <= th1;
      row2 <= row1;
      gx2  <= gx_c;
      gy2  <= gy_c;
    end
  end

  logic [GW-1:0]      ax, ay;
  logic [SW-1:0]      sum;
  logic [CW-1:0]      sum_c;
  logic [OUT_W_P-1:0] res;

  always_comb begin
    ax    = gx2[GW-1] ? (~gx2 + GW'(1)) : gx2;
    ay    = gy2[GW-1] ? (~gy2 + GW'(1)) : gy2;
    sum   = {1'b0, ax} + {1'b0, ay};
    sum_c = CW'(sum);
    if (b2) begin
      res = '0;
    end else if (md2) begin
      res = (sum_c > CW'(th2)) ? '1 : '0;
    end else begin
      res = (sum_c > OUT_MAX) ? '1 : sum_c[OUT_W_P-1:0];
    end
  end

  logic [YW-1:0] row3;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_valid_o <= 1'b0;
      m_user_o  <= 1'b0;
      m_last_o  <= 1'b0;
      m_data_o  <= '0;
      row3      <= '0;
    end else if (adv) begin
      m_valid_o <= v2;
      m_user_o  <= v2 & u2;
      m_last_o  <= v2 & l2;
      m_data_o  <= res;
      row3      <= row2;
    end
  end

  // Frame height is the count of rows started since SOF, so the pulse marks the newest row's EOL
  assign frame_done_o = m_valid_o & m_ready_i & m_last_o &
                        ((row3 + YW'(1)) == (y_q + YW'(x_q != '0)));

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Parametrised successor to the fixed 640x480 Sobel datapath. One clock, AXI-Stream-style pixel in and out, with full backpressure.
- Builds a 3x3 window from two internal line buffers and computes the L1 gradient magnitude |Gx|+|Gy|.
- Output is either a saturated magnitude or a binary edge map. Line width is set at run time; borders are forced to zero.
- Sits between the camera FIFO and any display or storage sink. Emits SOF/EOL sideband so the sink needs no counters of its own.

Parameters:
- WIDTH_P, 8, input pixel width (unsigned).
- OUT_W_P, 8, output pixel width. Magnitude saturates to 2^OUT_W_P-1.
- MAX_LINE_W_P, 1024, line buffer depth; maximum supported cfg_width_i.
- XW_P, $clog2(MAX_LINE_W_P), column counter width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_width_i  in  XW_P+1  active line width W (3..MAX_LINE_W_P); sampled on SOF beat
- cfg_mode_i  in  1  0 = saturated magnitude, 1 = binary threshold; sampled on SOF beat
- cfg_thresh_i  in  OUT_W_P  threshold for mode 1; sampled on SOF beat
- s_data_i  in  WIDTH_P  input pixel
- s_user_i  in  1  start of frame (first pixel)
- s_last_i  in  1  end of line
- s_valid_i  in  1  input valid
- s_ready_o  out  1  input ready
- m_data_o  out  OUT_W_P  output pixel
- m_user_o  out  1  output start of frame
- m_last_o  out  1  output end of line
- m_valid_o  out  1  output valid
- m_ready_i  in  1  output ready
- line_err_o  out  1  sticky: s_last_i position disagreed with W; cleared on next SOF beat
- frame_done_o  out  1  one-cycle pulse when output beat with m_last_o at row H-1 of the counted frame is accepted (H = rows since SOF)

Behaviour:
- Reset: all outputs 0. Pipeline valids, counters and sticky flag cleared. Line buffer contents are not reset.
- Beat = valid & ready on that side.
- Pipeline: 3 register stages (window/capture, Gx/Gy, abs+sum+saturate/threshold). Latency 3 cycles from input beat to m_valid_o when unstalled.
- Global stall: adv = ~m_valid_o | m_ready_i. s_ready_o = adv. All stages hold when adv=0.
- No combinational path from s_valid_i to m_valid_o.
- Exactly one output beat per input beat, in order. m_user_o and m_last_o are s_user_i and s_last_i delayed in lockstep.
- Position counters x, y:
  - SOF beat: x=0, y=0; cfg latched.
  - Other beats: x increments.
  - s_last_i beat: next x=0, y+1.
  - x reaching W-1 without s_last_i: wraps to 0, y+1, sets line_err_o.
  - s_last_i with x != W-1: treated as EOL, sets line_err_o.
- Line buffers: two rows, addressed by x. Read and write on the same beat (read-before-write). A 3x3 shift window is fed from {lb1[x], lb0[x], s_data_i}.
- Window alignment: output at position (y,x) is centred on input (y-1,x-1). The output image is shifted one pixel down-right. Forced to 0 when y<2 or x<2.
- Gx = (p02+2p12+p22)-(p00+2p10+p20). Gy = (p20+2p21+p22)-(p00+2p01+p02).
  - Signed width WIDTH_P+3.
  - Sum |Gx|+|Gy| unsigned, width WIDTH_P+4, no overflow.
- Mode 0: m_data_o = min(sum, 2^OUT_W_P-1).
- Mode 1: m_data_o = (sum > cfg_thresh_i) ? all ones : 0.
- Config changes mid-frame have no effect until the next SOF beat.
- SOF mid-line: the counters restart immediately. In-flight pipeline beats still drain with their original sideband.
- Reset mid-frame: pipeline is flushed. The next frame must begin with SOF. Pixels before the first SOF are processed with W=MAX_LINE_W_P, mode 0, thresh 0.

Test Plan:
- Flat frame, W=8, 6 rows, all pixels 100, mode 0 -> 48 output beats, every m_data_o=0. m_user_o on beat 0, m_last_o on beats 7,15,..,47. line_err_o=0.
- Vertical edge, W=8, 6 rows (cols 0-3 = 0, cols 4-7 = 200), mode 0 -> in rows 2-5, output cols 4 and 5 = 255 (raw sum 800). All other outputs 0.
- Same frame in mode 1 with thresh=50, then OUT_W_P=12 build in mode 0 -> binary 255 at cols 4,5, else 0. The 12-bit build gives 800 at the same positions.
- Random m_ready_i (about 50% duty) plus random s_valid_i gaps, random 16x10 image -> output sequence matches the reference model bit-exactly. No beat dropped or duplicated. m_data_o is stable while m_valid_o & ~m_ready_i.
- W=8 but s_last_i asserted at x=5 -> line_err_o rises the cycle after that beat, stays high, and clears on the next SOF beat.
- rstn_i pulsed low mid-frame (row 3) -> all outputs 0 during reset. A fresh SOF frame afterwards produces correct outputs with borders zero.
